// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared width defaults, FSM encoding and full-mask constant
//               for the 1-to-256 bit demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int c_WIDTH = 256;
   localparam int c_SEL_W = 8;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [c_WIDTH-1:0] c_MASK_FULL = '1;

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
// Module      : dec_onehot
// Description : Binary index to one-hot decoder (SEL_W -> WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module dec_onehot #(
   parameter int SEL_W = 8,
   parameter int WIDTH = 256
) (
   input  logic [SEL_W-1:0] idx,
   output logic [WIDTH-1:0] onehot
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      assign onehot[g] = (idx == SEL_W'(g));
   end

endmodule
`default_nettype wire

// File: rtl/demux_1x256_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x256_reg
// Description : Registered 1-to-WIDTH bit demux; assembles a word bit by bit
//               and presents it with a valid/ack handshake once complete.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x256_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = c_WIDTH,
   parameter int SEL_W = c_SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic [SEL_W-1:0] sel,
   input  logic             auto_inc,
   input  logic             clr,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [SEL_W-1:0] wr_ptr
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_mask;
   logic [WIDTH-1:0]   w_mask_nxt;
   logic [WIDTH-1:0]   r_data;
   logic [WIDTH-1:0]   w_data_nxt;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   w_ptr_nxt;
   logic [SEL_W-1:0]   w_idx;
   logic [WIDTH-1:0]   w_onehot;
   logic [WIDTH-1:0]   w_mask_set;
   logic               w_full;

   assign w_idx = auto_inc ? r_ptr : sel;

   // One decoder drives both the data write enable and the mask update.
   dec_onehot #(
      .SEL_W (SEL_W),
      .WIDTH (WIDTH)
   ) u_dec (
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   assign w_mask_set = r_mask | w_onehot;

   if (WIDTH == c_WIDTH) begin : g_full_const
      assign w_full = (w_mask_set == c_MASK_FULL);
   end else begin : g_full_reduce
      assign w_full = &w_mask_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
         r_mask  <= '0;
         r_data  <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_data  <= w_data_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_data_nxt  = r_data;
      w_ptr_nxt   = r_ptr;
      // Flush wins over any concurrent write or ack.
      if (clr) begin
         w_state_nxt = ST_FILL;
         w_mask_nxt  = '0;
         w_data_nxt  = '0;
         w_ptr_nxt   = '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (in_valid) begin
                  w_data_nxt = (r_data & ~w_onehot) | ({WIDTH{in_bit}} & w_onehot);
                  w_mask_nxt = w_mask_set;
                  if (auto_inc) begin
                     w_ptr_nxt = r_ptr + 1'b1;
                  end
                  if (w_full) begin
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // Data is kept after ack; the next frame overwrites it.
               if (out_ack) begin
                  w_state_nxt = ST_FILL;
                  w_mask_nxt  = '0;
                  w_ptr_nxt   = '0;
               end
            end
            default: w_state_nxt = ST_FILL;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_FILL);
   assign out_valid = (r_state == ST_HOLD);
   assign out_data  = r_data;
   assign wr_ptr    = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x256_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x256_reg
// Description : Self-checking bench for demux_1x256_reg (vector table plus
//               reference-model scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x256_reg;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_bit;
   logic [7:0]   sel;
   logic         auto_inc;
   logic         clr;
   logic [255:0] out_data;
   logic         out_valid;
   logic         out_ack;
   logic [7:0]   wr_ptr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [255:0] data;
      logic         valid;
      logic         ready;
      logic [7:0]   ptr;
   } exp_t;

   typedef struct {
      logic       iv;
      logic       ib;
      logic [7:0] s;
      logic       ai;
      logic       cl;
      logic       ak;
      logic       ev;
      logic       er;
      logic [7:0] ep;
      logic [7:0] elo;
   } vec_t;

   exp_t         sb[$];
   vec_t         tbl[9];
   logic [255:0] m_data;
   logic [255:0] m_mask;
   logic [7:0]   m_ptr;
   logic         m_hold;
   logic [7:0]   pat;
   logic [255:0] exp_a3;

   demux_1x256_reg dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .sel       (sel),
      .auto_inc  (auto_inc),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .wr_ptr    (wr_ptr)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic iv, input logic ib, input logic [7:0] s,
                         input logic ai, input logic cl, input logic ak);
      in_valid = iv;
      in_bit   = ib;
      sel      = s;
      auto_inc = ai;
      clr      = cl;
      out_ack  = ak;
   endtask

   task automatic model_reset();
      m_data = '0;
      m_mask = '0;
      m_ptr  = '0;
      m_hold = 1'b0;
      sb.delete();
   endtask

   // Reference model advanced with the inputs about to be clocked in.
   task automatic cyc();
      exp_t e;
      int   idx;
      if (clr) begin
         m_data = '0;
         m_mask = '0;
         m_ptr  = '0;
         m_hold = 1'b0;
      end else if (!m_hold) begin
         if (in_valid) begin
            idx = auto_inc ? int'(m_ptr) : int'(sel);
            m_data[idx] = in_bit;
            m_mask[idx] = 1'b1;
            if (auto_inc) m_ptr = m_ptr + 8'd1;
            if (m_mask == {256{1'b1}}) m_hold = 1'b1;
         end
      end else if (out_ack) begin
         m_hold = 1'b0;
         m_mask = '0;
         m_ptr  = '0;
      end
      sb.push_back('{m_data, m_hold, ~m_hold, m_ptr});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sb_data",  out_data, e.data);
      check("sb_valid", 256'(out_valid), 256'(e.valid));
      check("sb_ready", 256'(in_ready), 256'(e.ready));
      check("sb_ptr",   256'(wr_ptr), 256'(e.ptr));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_data"},  out_data, '0);
      check({tag, "_valid"}, 256'(out_valid), 256'(1'b0));
      check({tag, "_ready"}, 256'(in_ready), 256'(1'b1));
      check({tag, "_ptr"},   256'(wr_ptr), 256'(8'd0));
   endtask

   // Asserts rst_n between clock edges and checks outputs before any edge.
   task automatic async_rst(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals(tag);
      model_reset();
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      model_reset();
      pat    = 8'b1010_0011;
      exp_a3 = {32{8'hA3}};

      //            iv    ib    sel   ai    clr   ack   ev    er    ptr   lo
      tbl[0] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'h01};
      tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'h01};
      tbl[2] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h05};
      tbl[3] = '{1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h85};
      tbl[4] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h84};
      tbl[5] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h84};
      tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'h84};
      tbl[7] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'h00};
      tbl[8] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'h08};

      #12;
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].iv, tbl[i].ib, tbl[i].s, tbl[i].ai, tbl[i].cl, tbl[i].ak);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), 256'(out_valid), 256'(tbl[i].ev));
         check($sformatf("vec%0d_ready", i), 256'(in_ready), 256'(tbl[i].er));
         check($sformatf("vec%0d_ptr", i), 256'(wr_ptr), 256'(tbl[i].ep));
         check($sformatf("vec%0d_lo", i), 256'(out_data[7:0]), 256'(tbl[i].elo));
      end

      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      cyc();

      // Full auto-increment frame with a repeating A3 pattern.
      for (int i = 0; i < 256; i++) begin
         set_in(1'b1, pat[i % 8], 8'd0, 1'b1, 1'b0, 1'b0);
         cyc();
         if (i == 254) check("a3_not_yet", 256'(out_valid), 256'(1'b0));
      end
      check("a3_valid", 256'(out_valid), 256'(1'b1));
      check("a3_data", out_data, exp_a3);
      check("a3_ptr_wrap", 256'(wr_ptr), 256'(8'd0));

      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
         cyc();
         check("hold_bit0", 256'(out_data[0]), 256'(1'b1));
         check("hold_ready", 256'(in_ready), 256'(1'b0));
      end

      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      check("ack_ready", 256'(in_ready), 256'(1'b1));
      check("ack_keeps_data", out_data, exp_a3);

      // Addressed writes 0..254, a duplicate, then the last position.
      for (int s = 0; s < 255; s++) begin
         set_in(1'b1, 1'($urandom_range(1, 0)), 8'(s), 1'b0, 1'b0, 1'b0);
         cyc();
      end
      check("addr254_valid", 256'(out_valid), 256'(1'b0));
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
         cyc();
      end
      check("dup7_valid", 256'(out_valid), 256'(1'b0));
      set_in(1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0);
      cyc();
      check("addr255_valid", 256'(out_valid), 256'(1'b1));

      async_rst("rst_hold");
      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc();

      // Mixed mode: addressed lower half, then a full auto pass.
      for (int s = 0; s < 128; s++) begin
         set_in(1'b1, 1'($urandom_range(1, 0)), 8'(s), 1'b0, 1'b0, 1'b0);
         cyc();
      end
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            check("mix_pre_ptr", 256'(wr_ptr), 256'(8'd255));
            check("mix_pre_valid", 256'(out_valid), 256'(1'b0));
         end
         set_in(1'b1, 1'($urandom_range(1, 0)), 8'd0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      check("mix_valid", 256'(out_valid), 256'(1'b1));
      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      cyc();

      // Flush after 100 writes, with a colliding write that must be dropped.
      for (int i = 0; i < 100; i++) begin
         set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      check("pre_clr_ptr", 256'(wr_ptr), 256'(8'd100));
      set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
      cyc();
      check("clr_data", out_data, '0);
      check("clr_ptr", 256'(wr_ptr), 256'(8'd0));
      for (int i = 0; i < 255; i++) begin
         set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      check("clr_mask_empty", 256'(out_valid), 256'(1'b0));
      set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      check("clr_refill_valid", 256'(out_valid), 256'(1'b1));
      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      cyc();

      for (int i = 0; i < 50; i++) begin
         set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
         cyc();
      end
      async_rst("rst_mid");

      set_in(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      check("fill_ack_ready", 256'(in_ready), 256'(1'b1));
      set_in(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
      cyc();
      check("fill_ack_ptr", 256'(wr_ptr), 256'(8'd1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
